// File: rtl/reaction_controller.sv
// reaction_controller: round sequencer for the reaction-time tester.
// Random wait, GO lamp, counter run/freeze, false-start, timeout, best time.
//
// Ports:
//   clk_50M      clock, all logic on rising edge
//   rst          synchronous active-high reset
//   btn_start    debounced start button (level)
//   btn_react    debounced reaction button (level)
//   CounterOut   current ms count from the counter (saturates at 999)
//   CounterFlag  counter control: 00 clear, 01 hold, 10 count
//   state        round state code for the display
//   led_wait     lit while waiting for GO
//   led_go       lit while the player must react
//   foul         lit after a false start
//   timeout      lit after the counter saturated
//   best_ms      best valid reaction time since reset
module reaction_controller #(
    parameter int TICK_CYCLES  = 50000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_react,
    input  logic [9:0] CounterOut,
    output logic [1:0] CounterFlag,
    output logic [2:0] state,
    output logic       led_wait,
    output logic       led_go,
    output logic       foul,
    output logic       timeout,
    output logic [9:0] best_ms
);

    localparam int PRE_W =
        (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX =
        PRE_W'(TICK_CYCLES - 1);
    localparam logic [9:0]  CNT_SAT   = 10'd999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_GO      = 3'd2,
        S_DONE    = 3'd3,
        S_FOUL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t           st;
    state_t           st_nxt;
    logic             prev_start;
    logic             prev_react;
    logic             start_edge;
    logic             react_edge;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [11:0]      delay_ms;
    logic [11:0]      ms_cnt;
    logic [PRE_W-1:0] pre;
    logic             pre_wrap;
    logic             arm_done;
    logic             arm_entry;
    logic             cap_pending;

    function automatic logic [1:0] flag_of(input state_t s);
        case (s)
            S_GO:                      return 2'b10;
            S_DONE, S_FOUL, S_TIMEOUT: return 2'b01;
            default:                   return 2'b00;
        endcase
    endfunction

    assign state = st;

    always_comb begin
        start_edge = btn_start & ~prev_start;
        react_edge = btn_react & ~prev_react;
        // Fibonacci taps 16/14/13/11 in right-shift form
        lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        pre_wrap   = (pre == PRE_MAX);
        arm_done   = pre_wrap && ((ms_cnt + 12'd1) == delay_ms);
    end

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE: begin
                if (start_edge)
                    st_nxt = S_ARM;
            end
            S_ARM: begin
                // a press that lands with the GO tick is still a foul
                if (react_edge)
                    st_nxt = S_FOUL;
                else if (arm_done)
                    st_nxt = S_GO;
            end
            S_GO: begin
                // a press that lands with saturation still counts
                if (react_edge)
                    st_nxt = S_DONE;
                else if (CounterOut == CNT_SAT)
                    st_nxt = S_TIMEOUT;
            end
            S_DONE, S_FOUL, S_TIMEOUT: begin
                if (start_edge)
                    st_nxt = S_ARM;
                else if (react_edge)
                    st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
        arm_entry = (st_nxt == S_ARM) && (st != S_ARM);
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            st          <= S_IDLE;
            prev_start  <= 1'b1;
            prev_react  <= 1'b1;
            lfsr        <= LFSR_SEED;
            delay_ms    <= '0;
            ms_cnt      <= '0;
            pre         <= '0;
            cap_pending <= 1'b0;
            best_ms     <= CNT_SAT;
            CounterFlag <= 2'b00;
            led_wait    <= 1'b0;
            led_go      <= 1'b0;
            foul        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            st         <= st_nxt;
            prev_start <= btn_start;
            prev_react <= btn_react;
            lfsr       <= {lfsr_fb, lfsr[15:1]};

            if (arm_entry) begin
                delay_ms <= 12'(MIN_DELAY_MS)
                          + {1'b0, lfsr[10:0]};
                ms_cnt   <= '0;
                pre      <= '0;
            end else if (st == S_ARM) begin
                if (pre_wrap) begin
                    pre    <= '0;
                    ms_cnt <= ms_cnt + 12'd1;
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end

            // capture one edge late so the counter's final
            // increment (it still saw 10) is included
            if (cap_pending && st == S_DONE &&
                CounterOut < best_ms)
                best_ms <= CounterOut;
            cap_pending <= (st_nxt == S_DONE) && (st != S_DONE);

            CounterFlag <= flag_of(st_nxt);
            led_wait    <= (st_nxt == S_ARM);
            led_go      <= (st_nxt == S_GO);
            foul        <= (st_nxt == S_FOUL);
            timeout     <= (st_nxt == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_reaction_controller.sv
// Bench for reaction_controller: counter model, timestamp-based
// reference model, per-cycle compare plus literal anchors.
module tb_reaction_controller;

    localparam int T   = 10;
    localparam int MIN = 2;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b1;
    logic       btn_react = 1'b1;
    logic [9:0] CounterOut = '0;
    logic [1:0] CounterFlag;
    logic [2:0] state;
    logic       led_wait;
    logic       led_go;
    logic       foul;
    logic       timeout;
    logic [9:0] best_ms;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    reaction_controller #(
        .TICK_CYCLES (T),
        .MIN_DELAY_MS(MIN)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_react  (btn_react),
        .CounterOut (CounterOut),
        .CounterFlag(CounterFlag),
        .state      (state),
        .led_wait   (led_wait),
        .led_go     (led_go),
        .foul       (foul),
        .timeout    (timeout),
        .best_ms    (best_ms)
    );

    always #5 clk_50M = ~clk_50M;

    // millisecond counter environment
    int cdiv = 0;
    always @(posedge clk_50M) begin
        case (CounterFlag)
            2'b00: begin
                CounterOut <= '0;
                cdiv       <= 0;
            end
            2'b10: begin
                if (cdiv == T - 1) begin
                    cdiv <= 0;
                    if (CounterOut < 10'd999)
                        CounterOut <= CounterOut + 10'd1;
                end else begin
                    cdiv <= cdiv + 1;
                end
            end
            default: ;
        endcase
    end

    // reference model: ARM ends at an absolute cycle stamp
    int          m_state = 0;
    bit          m_ps = 1'b1;
    bit          m_pr = 1'b1;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_best = 999;
    bit          m_cap = 1'b0;
    longint      cyc = 0;
    longint      m_go_at = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic int exp_flag(input int s);
        if (s == 2) return 2;
        if (s >= 3 && s <= 5) return 1;
        return 0;
    endfunction

    always @(posedge clk_50M) begin
        bit se;
        bit re;
        int ns;
        int dly;
        cyc <= cyc + 1;
        if (rst) begin
            m_state <= 0;
            m_ps    <= 1'b1;
            m_pr    <= 1'b1;
            m_lfsr  <= 16'hACE1;
            m_best  <= 999;
            m_cap   <= 1'b0;
        end else begin
            se  = btn_start && !m_ps;
            re  = btn_react && !m_pr;
            ns  = m_state;
            dly = MIN + int'(m_lfsr[10:0]);
            case (m_state)
                0: if (se) ns = 1;
                1: if (re) ns = 4;
                   else if (cyc == m_go_at) ns = 2;
                2: if (re) ns = 3;
                   else if (CounterOut == 10'd999) ns = 5;
                3, 4, 5: if (se) ns = 1;
                   else if (re) ns = 0;
                default: ns = 0;
            endcase
            if (ns == 1 && m_state != 1)
                m_go_at <= cyc + longint'(dly * T);
            if (m_cap && m_state == 3 && int'(CounterOut) < m_best)
                m_best <= int'(CounterOut);
            m_cap   <= (ns == 3 && m_state != 3);
            m_state <= ns;
            m_ps    <= btn_start;
            m_pr    <= btn_react;
            m_lfsr  <= lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic fail_wait(input string nm);
        checks++;
        errors++;
        $display("FAIL wait_%s: bound expired at %0t", nm, $time);
    endtask

    // per-cycle compare against the model
    always @(negedge clk_50M) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("flag", 32'(CounterFlag), 32'(exp_flag(m_state)));
            chk("led_wait", 32'(led_wait), 32'(m_state == 1));
            chk("led_go", 32'(led_go), 32'(m_state == 2));
            chk("foul", 32'(foul), 32'(m_state == 4));
            chk("timeout", 32'(timeout), 32'(m_state == 5));
            chk("best", 32'(best_ms), 32'(m_best));
        end
    end

    task automatic press(input bit s, input bit r);
        btn_start = s;
        btn_react = r;
        @(negedge clk_50M);
        btn_start = 1'b0;
        btn_react = 1'b0;
        @(negedge clk_50M);
    endtask

    // press start when the next delay will be short
    task automatic start_short();
        int n = 0;
        while (m_lfsr[10:0] >= 11'd128 && n < 1000) begin
            @(negedge clk_50M);
            n++;
        end
        if (m_lfsr[10:0] >= 11'd128) fail_wait("lfsr");
        press(1'b1, 1'b0);
    endtask

    task automatic wait_model(input int s, input int maxc,
                              input string nm);
        int n = 0;
        while (m_state != s && n < maxc) begin
            @(negedge clk_50M);
            n++;
        end
        if (m_state != s) fail_wait(nm);
    endtask

    task automatic react_at(input int v);
        int n = 0;
        while (int'(CounterOut) != v && n < 12000) begin
            @(negedge clk_50M);
            n++;
        end
        if (int'(CounterOut) != v) fail_wait("counter");
        else press(1'b0, 1'b1);
    endtask

    task automatic to_idle();
        for (int k = 0; k < 4 && m_state != 0; k++)
            press(1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        int n;
        // reset with both buttons held
        @(negedge clk_50M);
        chk_en = 1'b1;
        repeat (2) @(negedge clk_50M);
        chk("rst_state", 32'(state), 0);
        chk("rst_flag", 32'(CounterFlag), 0);
        chk("rst_leds", 32'({led_wait, led_go, foul, timeout}), 0);
        chk("rst_best", 32'(best_ms), 999);
        chk("model_seed", 32'(m_lfsr), 32'h0000ACE1);
        rst = 1'b0;
        @(negedge clk_50M);
        chk("model_lfsr1", 32'(m_lfsr), 32'h00005670);
        @(negedge clk_50M);
        chk("model_lfsr2", 32'(m_lfsr), 32'h0000AB38);
        repeat (5) @(negedge clk_50M);
        chk("held_no_edge", 32'(state), 0);
        btn_start = 1'b0;
        btn_react = 1'b0;
        repeat (3) @(negedge clk_50M);

        // normal round, react at 123
        start_short();
        chk("arm_entry", 32'(state), 1);
        wait_model(2, 3000, "go1");
        chk("go_flag", 32'(CounterFlag), 2);
        react_at(123);
        chk("done_flag", 32'(CounterFlag), 1);
        chk("best_123", 32'(best_ms), 123);
        repeat (30) @(negedge clk_50M);
        chk("frozen_123", 32'(CounterOut), 123);

        // false start 5 cycles into ARM
        to_idle();
        press(1'b1, 1'b0);
        repeat (3) @(negedge clk_50M);
        press(1'b0, 1'b1);
        chk("foul_state", 32'(state), 4);
        chk("foul_lamp", 32'(foul), 1);
        chk("foul_cnt", 32'(CounterOut), 0);
        chk("foul_best", 32'(best_ms), 123);
        press(1'b0, 1'b1);
        chk("foul_to_idle", 32'(state), 0);

        // timeout
        start_short();
        wait_model(2, 3000, "go2");
        wait_model(5, 11000, "timeout");
        @(negedge clk_50M);
        chk("to_lamp", 32'(timeout), 1);
        chk("to_flag", 32'(CounterFlag), 1);
        chk("to_best", 32'(best_ms), 123);

        // best tracking: 200 then 50
        start_short();
        wait_model(2, 3000, "go3");
        react_at(200);
        chk("best_keep", 32'(best_ms), 123);
        press(1'b0, 1'b1);
        chk("done_to_idle", 32'(state), 0);
        start_short();
        wait_model(2, 3000, "go4");
        react_at(50);
        chk("best_50", 32'(best_ms), 50);

        // react on the very edge GO would be entered
        start_short();
        n = 0;
        while (cyc != m_go_at && n < 3000) begin
            @(negedge clk_50M);
            n++;
        end
        if (cyc != m_go_at) fail_wait("go_edge");
        else press(1'b0, 1'b1);
        chk("coll_foul", 32'(state), 4);

        // react on the edge the counter shows 999
        start_short();
        wait_model(2, 3000, "go5");
        react_at(999);
        chk("coll_done", 32'(state), 3);
        chk("coll_best", 32'(best_ms), 50);

        // reset in the middle of GO
        start_short();
        wait_model(2, 3000, "go6");
        repeat (20) @(negedge clk_50M);
        rst = 1'b1;
        @(negedge clk_50M);
        chk("rst_go_state", 32'(state), 0);
        chk("rst_go_flag", 32'(CounterFlag), 0);
        chk("rst_go_best", 32'(best_ms), 999);
        rst = 1'b0;
        repeat (3) @(negedge clk_50M);

        // randomized rounds
        for (int i = 0; i < 15; i++) begin
            int act;
            to_idle();
            act = int'($urandom_range(0, 2));
            if (act == 0) begin
                press(1'b1, 1'b0);
                repeat ($urandom_range(0, 25)) @(negedge clk_50M);
                press(1'b0, 1'b1);
            end else if (act == 1) begin
                start_short();
                if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0);
                wait_model(2, 3000, "go_rand");
                if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0);
                react_at(int'($urandom_range(3, 60)));
                repeat ($urandom_range(1, 5)) @(negedge clk_50M);
            end else begin
                for (int k = 0; k < 6; k++) begin
                    press(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 4))
                        @(negedge clk_50M);
                end
            end
        end
        to_idle();
        repeat (5) @(negedge clk_50M);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
